t_counter_mod: RTL and testbench



---
 rtl/t_counter_mod_pkg.sv | 21 ++
 rtl/t_counter_mod_t_cell.sv | 33 +++
 rtl/t_counter_mod.sv | 109 ++++++++++
 tb/tb_t_counter_mod.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/t_counter_mod_pkg.sv
// Shared definitions for the toggle-cell modulo counter family.
package t_counter_mod_pkg;

    // Direction encoding seen on the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Ceiling log2: number of bits needed to hold values 0..value-1.
    // Callers use it to size WIDTH from a modulus (clog2(10) == 4).
    function automatic int clog2(input longint unsigned value);
        int bits;
        bits = 0;
        for (int i = 0; i < 64; i++) begin
            if ((64'd1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/t_counter_mod_t_cell.sv
// Single toggle flip-flop: Q inverts on every clock edge where t is high.
module t_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next value: invert when toggling, otherwise keep.
    always_comb begin
        q_d = q_q;
        if (t) begin
            q_d = ~q_q;
        end
    end

    // State bit with asynchronous active-low reset to RST_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_counter_mod.sv
// Modulo up/down counter built from a bank of toggle cells, with clear,
// clamped parallel load, terminal count (cascade carry) and a wrap pulse.
module t_counter_mod
    import t_counter_mod_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter longint unsigned  MOD       = 16,
    parameter longint unsigned  RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MOD == 2**WIDTH is representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 1 || WIDTH > 32 || MOD < 64'd2 || MOD > (64'd1 << WIDTH) ||
        RESET_VAL >= MOD) begin : g_bad_params
        $fatal(1, "t_counter_mod: illegal WIDTH/MOD/RESET_VAL combination");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] t_vec;
    logic             wrap_q;
    logic             wrap_d;
    logic             tc_c;

    // Next count and wrap: clr > load > en > hold. Counting up from any
    // value at or above MOD-1 wraps to zero, so an out-of-range count recovers.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = RST_VAL_W;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                count_d = load_val;
            end else begin
                count_d = MAX_VAL;
            end
        end else if (en) begin
            if (up == DIR_UP) begin
                if (count_q >= MAX_VAL) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // Terminal count: high in the cycle whose edge will wrap, masked by clr/load.
    always_comb begin
        tc_c = en & ~clr & ~load &
               (((up == DIR_UP)   & (count_q == MAX_VAL)) |
                ((up == DIR_DOWN) & (count_q == '0)));
    end

    // Toggle enables: a bit flips only where its next value differs.
    always_comb begin
        t_vec = count_q ^ count_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell #(
            .RST_VAL (RST_VAL_W[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[i]),
            .q     (count_q[i])
        );
    end

    // Wrap pulse register, cleared asynchronously with the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_c;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_t_counter_mod.sv
// Directed bench for t_counter_mod: MOD=10 unit, MOD=16 unit and a
// two-stage MOD=10 cascade. Expected count/wrap values are queued when a
// step is driven and compared after the clock edge that produces them.
module tb_t_counter_mod;
    import t_counter_mod_pkg::*;

    localparam int CW = clog2(10);

    logic clk;
    logic rst_n;

    // Unit a: modulus 10
    logic       a_clr, a_load, a_en, a_up;
    logic [3:0] a_lv, a_count;
    logic       a_tc, a_wrap;

    // Unit b: modulus 16
    logic       b_clr, b_load, b_en, b_up;
    logic [3:0] b_lv, b_count;
    logic       b_tc, b_wrap;

    // Cascade
    logic          c_rst_n, c_en;
    logic [CW-1:0] c0_count, c1_count;
    logic          c0_tc, c1_tc, c0_wrap, c1_wrap;
    logic [CW-1:0] c_zero;

    int total;
    int bad;

    logic [4:0] exp_q[$];
    logic [7:0] casc_q[$];

    t_counter_mod #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .load_val(a_lv),
        .en(a_en), .up(a_up), .count(a_count), .tc(a_tc), .wrap(a_wrap)
    );

    t_counter_mod #(.WIDTH(4), .MOD(16), .RESET_VAL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .load_val(b_lv),
        .en(b_en), .up(b_up), .count(b_count), .tc(b_tc), .wrap(b_wrap)
    );

    t_counter_mod #(.WIDTH(CW), .MOD(10), .RESET_VAL(0)) u_c0 (
        .clk(clk), .rst_n(c_rst_n), .clr(1'b0), .load(1'b0), .load_val(c_zero),
        .en(c_en), .up(1'b1), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap)
    );

    t_counter_mod #(.WIDTH(CW), .MOD(10), .RESET_VAL(0)) u_c1 (
        .clk(clk), .rst_n(c_rst_n), .clr(1'b0), .load(1'b0), .load_val(c_zero),
        .en(c0_tc), .up(1'b1), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of controls on unit a (sel=0) or b (sel=1), check tc
    // before the edge, queue the expected count/wrap, compare after the edge.
    task automatic step(input bit sel, input logic c, input logic l,
                        input logic [3:0] lv, input logic e, input logic u,
                        input logic x_tc, input logic [3:0] x_cnt,
                        input logic x_wrap, input string tag);
        logic [4:0] want;
        logic [4:0] got;
        if (sel) begin
            b_clr = c; b_load = l; b_lv = lv; b_en = e; b_up = u;
        end else begin
            a_clr = c; a_load = l; a_lv = lv; a_en = e; a_up = u;
        end
        #1;
        chk({tag, ".tc"}, sel ? b_tc : a_tc, x_tc);
        exp_q.push_back({x_wrap, x_cnt});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = sel ? {b_wrap, b_count} : {a_wrap, a_count};
        chk({tag, ".count"}, got[3:0], want[3:0]);
        chk({tag, ".wrap"}, got[4], want[4]);
    endtask

    initial begin
        int wrap_seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        c_rst_n = 1'b0;
        c_en = 1'b0;
        c_zero = '0;
        a_clr = 0; a_load = 0; a_lv = 0; a_en = 0; a_up = 1;
        b_clr = 0; b_load = 0; b_lv = 0; b_en = 0; b_up = 1;

        // Reset state, sampled between edges while reset is held.
        #12;
        chk("rst.a_count", a_count, 0);
        chk("rst.a_wrap", a_wrap, 0);
        chk("rst.b_count", b_count, 0);
        chk("rst.c0_count", c0_count, 0);
        rst_n = 1'b1;

        // Count up through two full periods: 0..9,0..9 then back at 0.
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 4'd0, 1, 1, (k % 10) == 9, 4'((k + 1) % 10),
                 ((k + 1) % 10) == 0, "up");
        end

        // Count down from 0: wrap to 9, then 8, 7.
        step(0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 1, "down_wrap");
        step(0, 0, 0, 4'd0, 1, 0, 0, 4'd8, 0, "down8");
        step(0, 0, 0, 4'd0, 1, 0, 0, 4'd7, 0, "down7");

        // Loads override en; out-of-range values clamp to 9; tc masked.
        step(0, 0, 1, 4'd7,  1, 1, 0, 4'd7, 0, "load7");
        step(0, 0, 1, 4'd13, 1, 1, 0, 4'd9, 0, "load13");
        step(0, 0, 1, 4'd3,  1, 1, 0, 4'd3, 0, "load_at_tc");
        step(0, 0, 1, 4'd10, 1, 0, 0, 4'd9, 0, "load10");
        step(0, 0, 1, 4'd5,  1, 1, 0, 4'd5, 0, "load5");

        // clr beats load; clr also masks a pending down-wrap.
        step(0, 1, 1, 4'd8, 1, 1, 0, 4'd0, 0, "clr_load");
        step(0, 1, 0, 4'd0, 1, 0, 0, 4'd0, 0, "clr_down");

        // Asynchronous reset mid-cycle at count 6.
        step(0, 0, 1, 4'd6, 0, 1, 0, 4'd6, 0, "load6");
        a_load = 0; a_en = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid.count", a_count, 0);
        chk("rst_mid.wrap", a_wrap, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.after", a_count, 0);

        // Asynchronous reset while the wrap pulse is high.
        step(0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 1, "down_wrap2");
        a_en = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_wrap.count", a_count, 0);
        chk("rst_wrap.wrap", a_wrap, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-range modulus (2**WIDTH): 15 wraps to 0, then hold for three clocks.
        step(1, 0, 1, 4'd15, 0, 1, 0, 4'd15, 0, "m16_load");
        step(1, 0, 0, 4'd0, 1, 1, 1, 4'd0, 1, "m16_wrap");
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 4'd0, 0, 1, 0, 4'd0, 0, "m16_hold");
        end
        step(1, 0, 0, 4'd0, 1, 0, 1, 4'd15, 1, "m16_down_wrap");
        b_en = 0;

        // Cascade: stage1 en = stage0 tc. Expect (tens,ones) = (3,7) at 37
        // and (0,0) at 100, with exactly one stage1 wrap pulse.
        casc_q.push_back({4'd3, 4'd7});
        casc_q.push_back({4'd0, 4'd0});
        c_rst_n = 1'b1;
        c_en = 1'b1;
        wrap_seen = 0;
        for (int n = 1; n <= 100; n++) begin
            logic [7:0] want;
            @(posedge clk);
            #1;
            if (c1_wrap) wrap_seen++;
            if (n == 37 || n == 100) begin
                want = casc_q.pop_front();
                chk($sformatf("casc%0d.ones", n), 32'(c0_count), 32'(want[3:0]));
                chk($sformatf("casc%0d.tens", n), 32'(c1_count), 32'(want[7:4]));
            end
        end
        chk("casc.wrap_now", c1_wrap, 1);
        chk("casc.wrap_pulses", wrap_seen, 1);
        c_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
